// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback bundle (requesters, flush, output packet); master = arbiter side, slave = environment side
interface wb_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 5,
  parameter int PHYS_W = 6,
  parameter int EPOCH_W = 3
);
  logic [N_REQ-1:0] req_valid, req_ready, req_uses_rd;
  logic [N_REQ*ROB_W-1:0] req_rob_idx;
  logic [N_REQ*PHYS_W-1:0] req_prd;
  logic [N_REQ*32-1:0] req_data, req_pc;
  logic [N_REQ*EPOCH_W-1:0] req_epoch;
  logic flush_valid, out_valid, out_ready, out_uses_rd;
  logic [1:0] out_src;
  logic [ROB_W-1:0] out_rob_idx;
  logic [PHYS_W-1:0] out_prd;
  logic [31:0] out_data, out_pc;
  logic [EPOCH_W-1:0] out_epoch;
  modport master (
    input req_valid, req_uses_rd, req_rob_idx, req_prd, req_data, req_pc, req_epoch, flush_valid, out_ready,
    output req_ready, out_valid, out_src, out_rob_idx, out_prd, out_data, out_pc, out_epoch, out_uses_rd
  );
  modport slave (
    output req_valid, req_uses_rd, req_rob_idx, req_prd, req_data, req_pc, req_epoch, flush_valid, out_ready,
    input req_ready, out_valid, out_src, out_rob_idx, out_prd, out_data, out_pc, out_epoch, out_uses_rd
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with starvation override into one registered output entry; ports clk, rst, bus (wb_arbiter_if.master)
module wb_arbiter #(
  parameter int N_REQ = 4,
  parameter int ROB_W = 5,
  parameter int PHYS_W = 6,
  parameter int EPOCH_W = 3,
  parameter int STARVE_MAX = 7
) (
  input logic clk,
  input logic rst,
  wb_arbiter_if.master bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] wait_q [N_REQ];
  logic [1:0] rr_q, rr_d, g, src_q;
  logic [N_REQ-1:0] starve;
  logic found, can_load, grant, out_valid_q, uses_q;
  logic [ROB_W-1:0] rob_q;
  logic [PHYS_W-1:0] prd_q;
  logic [31:0] data_q, pc_q;
  logic [EPOCH_W-1:0] epoch_q;
  assign can_load = !out_valid_q || bus.out_ready;
  assign grant = can_load && !bus.flush_valid && !rst && found;
  assign bus.req_ready = grant ? N_REQ'(1) << g : '0;
  assign rr_d = !grant ? rr_q : (g == 2'(N_REQ - 1)) ? 2'd0 : g + 2'd1;
  always_comb begin
    g = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      starve[k] = bus.req_valid[k] && wait_q[k] == CW'(STARVE_MAX);
      if (!found && bus.req_valid[(int'(rr_q) + k) % N_REQ]) begin
        g = 2'((int'(rr_q) + k) % N_REQ);
        found = 1'b1;
      end
    end
    for (int k = N_REQ - 1; k >= 0; k--)
      if (starve[k]) g = 2'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      src_q <= '0;
      rob_q <= '0;
      prd_q <= '0;
      data_q <= '0;
      pc_q <= '0;
      epoch_q <= '0;
      uses_q <= 1'b0;
      rr_q <= '0;
      for (int k = 0; k < N_REQ; k++) wait_q[k] <= '0;
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < N_REQ; k++)
        wait_q[k] <= (bus.flush_valid || !bus.req_valid[k] || bus.req_ready[k]) ? '0 :
                     wait_q[k] + CW'(wait_q[k] != CW'(STARVE_MAX));
      if (grant) begin
        out_valid_q <= 1'b1;
        src_q <= g;
        rob_q <= bus.req_rob_idx[int'(g)*ROB_W +: ROB_W];
        prd_q <= bus.req_prd[int'(g)*PHYS_W +: PHYS_W];
        data_q <= bus.req_data[int'(g)*32 +: 32];
        pc_q <= bus.req_pc[int'(g)*32 +: 32];
        epoch_q <= bus.req_epoch[int'(g)*EPOCH_W +: EPOCH_W];
        uses_q <= bus.req_uses_rd[g];
      end else if (bus.flush_valid || bus.out_ready) out_valid_q <= 1'b0;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_src = src_q;
  assign bus.out_rob_idx = rob_q;
  assign bus.out_prd = prd_q;
  assign bus.out_data = data_q;
  assign bus.out_pc = pc_q;
  assign bus.out_epoch = epoch_q;
  assign bus.out_uses_rd = uses_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_REQ, 4, number of writeback requesters; index 0=ALU, 1=BRU, 2=LSU load, 3=LSU store.
- ROB_W, 5, ROB index width.
- PHYS_W, 6, physical register index width.
- EPOCH_W, 3, epoch tag width.
- STARVE_MAX, 7, wait cycles after which a requester is forced to win.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, N_REQ, per-requester result valid.
- req_ready, out, N_REQ, per-requester accept; one-hot or zero.
- req_rob_idx, in, N_REQ*ROB_W, packed ROB index; slice i belongs to requester i.
- req_prd, in, N_REQ*PHYS_W, packed destination physical register.
- req_data, in, N_REQ*32, packed result data.
- req_pc, in, N_REQ*32, packed instruction PC.
- req_epoch, in, N_REQ*EPOCH_W, packed epoch tag.
- req_uses_rd, in, N_REQ, result writes a register.
- flush_valid, in, 1, kill everything held or offered this cycle.
- out_valid, out, 1, writeback packet valid.
- out_ready, in, 1, ROB/PRF accepts the packet.
- out_src, out, 2, index of the winning requester.
- out_rob_idx, out_prd, out_data, out_pc, out_epoch, out_uses_rd, out, matching widths, registered packet fields.

Function
REQ-003 Output stage is a single registered entry. It can load when it is empty, or when out_valid&&out_ready in the same cycle; call this can_load.
REQ-004 One grant at most per cycle, and only when can_load && !flush_valid. A grant raises req_ready for that index only; the transfer is req_valid[i]&&req_ready[i].
REQ-005 req_ready[i] depends only on state, can_load, flush_valid and req_valid. No combinational path from req_ready to req_valid is permitted.
REQ-006 Arbitration is round-robin. A pointer rr_ptr resets to 0. The search starts at rr_ptr and proceeds upward modulo N_REQ; the first valid index wins. After a grant to index g, rr_ptr becomes (g+1) mod N_REQ. Without a grant, rr_ptr holds.
REQ-007 Each requester has a wait counter of width clog2(STARVE_MAX+1). It increments while req_valid[i] && !grant[i], saturates at STARVE_MAX, and clears on grant or when req_valid[i]=0.
REQ-008 Starvation override: if any counter equals STARVE_MAX, the lowest such index wins regardless of rr_ptr. rr_ptr then updates per REQ-006.
REQ-009 On a grant, the output entry captures the winner's fields. out_src=g and out_valid=1 on the next cycle. Latency from request to out_valid is 1 cycle.
REQ-010 The output holds all fields stable while out_valid && !out_ready.
REQ-011 On pop without a new grant, out_valid falls the next cycle. Pop and grant in the same cycle replace the entry with no bubble, giving a throughput of 1 packet per cycle.
REQ-012 flush_valid=1 has these effects:
- out_valid clears the next cycle.
- All req_ready are 0 in that cycle.
- All wait counters clear.
- rr_ptr holds.
- A pop in the flush cycle still completes on the consumer side.
REQ-013 Requesters must hold valid and fields stable until accepted. The arbiter does not buffer ungranted requests.
REQ-014 With all req_valid=0, no grant occurs and the output drains normally.

Reset
REQ-015 While rst=1 at a rising edge, the following take their reset values:
- out_valid=0, out_src=0, and all packet fields=0.
- rr_ptr=0 and all wait counters=0.
- req_ready=0 (combinational, forced during rst).
REQ-016 Reset mid-transfer discards the held packet. The first grant is possible in the first cycle with rst=0.

Verification
REQ-017 Single request: req_valid=4'b0001, out_ready=1, req_data[0]=0xDEADBEEF. Required: req_ready=0001 that cycle; next cycle out_valid=1, out_src=0, out_data=0xDEADBEEF.
REQ-018 All four requesting continuously, out_ready=1. Required: grants in the order 0,1,2,3,0, one per cycle, with out_valid continuously 1.
REQ-019 Backpressure: out_ready=0 for 3 cycles with req_valid=0010. Required: out fields stable and req_ready=0 after the first grant; on release, one pop and the next grant in the same cycle.
REQ-020 Starvation, STARVE_MAX=2: out_ready toggles so that requester 3 loses twice. Required: index 3 is granted on the next opportunity ahead of the rr_ptr order.
REQ-021 flush_valid pulse while out_valid=1 and req_valid=1111. Required: req_ready=0000 that cycle, out_valid=0 the next cycle, and counters cleared.
REQ-022 rst asserted while out_valid=1 and out_ready=0. Required: out_valid=0, rr_ptr=0 after one edge; a request in the next cycle is granted to index 0 first.
